// File: rtl/imm_ext_pipe_pkg.sv
// Shared encodings for the immediate extender pipeline.
// Decode drives in_op with these mode values.
package imm_ext_pipe_pkg;

    typedef logic [2:0] ext_op_t;

    localparam ext_op_t EXT_ZERO      = 3'd0;
    localparam ext_op_t EXT_SIGN      = 3'd1;
    localparam ext_op_t EXT_UPPER     = 3'd2;
    localparam ext_op_t EXT_SIGN_SHL2 = 3'd3;
    localparam ext_op_t EXT_ZERO_SHL2 = 3'd4;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between decode, the extender and execute.
// slave is the extender side, master the producer/consumer side.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    import imm_ext_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    ext_op_t          in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             err_sticky;

    modport slave (
        input  in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag,
        output out_err, err_sticky
    );

    modport master (
        output in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag,
        input  out_err, err_sticky
    );

endinterface

// File: rtl/imm_ext_pipe_ext_core.sv
// Combinational mode decode and extension of one immediate.
// Illegal modes produce zero data with err raised.
module ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_op_t          op,
    output logic [OUT_W-1:0] data,
    output logic             err
);

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        data = '0;
        err  = 1'b0;
        unique case (1'b1)
            (op == EXT_ZERO):      data = zext;
            (op == EXT_SIGN):      data = sext;
            (op == EXT_UPPER):     data = {imm, {(OUT_W-IN_W){1'b0}}};
            (op == EXT_SIGN_SHL2): data = sext << 2;
            (op == EXT_ZERO_SHL2): data = zext << 2;
            default:               err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a registered output and 2-entry skid buffer.
// M drives the outputs; S absorbs one entry while execute stalls.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input logic           clk,
    input logic           reset,
    imm_ext_pipe_if.slave bus
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    occ_t             state;
    occ_t             state_nx;
    entry_t           m_q;
    entry_t           s_q;
    entry_t           new_e;
    logic             rdy_q;
    logic             sticky_q;
    logic             in_fire;
    logic             out_fire;
    logic             m_valid;
    logic             load_m;
    logic             load_s;
    logic             shift;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    ext_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) u_core (
        .imm (bus.in_imm),
        .op  (bus.in_op),
        .data(ext_data),
        .err (ext_err)
    );

    assign new_e    = '{data: ext_data, tag: bus.in_tag, err: ext_err};
    assign m_valid  = (state != EMPTY);
    assign in_fire  = bus.in_valid && rdy_q;
    assign out_fire = m_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        shift    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx = ONE;
                    load_m   = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_m = 1'b1;
                end else if (in_fire) begin
                    state_nx = FULL;
                    load_s   = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nx = ONE;
                    shift    = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // rdy_q is low through reset and rises on the first clock after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q      <= '0;
            s_q      <= '0;
            rdy_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (load_m)     m_q <= new_e;
            else if (shift) m_q <= s_q;
            if (load_s)     s_q <= new_e;
            else if (shift) s_q <= '0;
            rdy_q    <= (state_nx != FULL);
            sticky_q <= sticky_q | (in_fire & ext_err);
        end
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = m_valid;
    assign bus.out_data   = m_q.data;
    assign bus.out_tag    = m_q.tag;
    assign bus.out_err    = m_q.err;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: vector tables, stall/reset sequences and a
// randomized stream checked against a queue-based reference model.
module tb_imm_ext_pipe;
    import imm_ext_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
    imm_ext_pipe_if #(.IN_W(8), .OUT_W(16), .TAG_W(5)) b8 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (b8)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string name, longint got, longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extension computed arithmetically from the mode definitions
    function automatic longint ref_ext(longint imm, int op,
                                       int in_w, int out_w,
                                       output bit err);
        longint mask;
        longint s;
        mask = (longint'(1) << out_w) - 1;
        s = (imm >= (longint'(1) << (in_w - 1)))
            ? imm - (longint'(1) << in_w) : imm;
        err = 1'b0;
        case (op)
            0: return imm & mask;
            1: return s & mask;
            2: return (imm * (longint'(1) << (out_w - in_w))) & mask;
            3: return (s * 4) & mask;
            4: return (imm * 4) & mask;
            default: begin
                err = 1'b1;
                return 0;
            end
        endcase
    endfunction

    typedef struct {
        logic [15:0] imm;
        ext_op_t     op;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  imm;
        ext_op_t     op;
        logic [15:0] exp;
    } vec8_t;

    typedef struct {
        longint data;
        int     tag;
        bit     err;
    } exp_t;

    vec_t  tbl[10];
    vec8_t tbl8[4];
    exp_t  q[$];

    initial begin
        int outs;
        int cyc;
        int tag_n;
        exp_t e;
        bit er;

        tbl[0] = '{16'h8001, EXT_SIGN,      32'hFFFF8001};
        tbl[1] = '{16'h8001, EXT_ZERO,      32'h00008001};
        tbl[2] = '{16'h8001, EXT_UPPER,     32'h80010000};
        tbl[3] = '{16'h8001, EXT_SIGN_SHL2, 32'hFFFE0004};
        tbl[4] = '{16'h8001, EXT_ZERO_SHL2, 32'h00020004};
        tbl[5] = '{16'hFFFF, EXT_SIGN,      32'hFFFFFFFF};
        tbl[6] = '{16'h7FFF, EXT_SIGN_SHL2, 32'h0001FFFC};
        tbl[7] = '{16'hFFFF, EXT_ZERO_SHL2, 32'h0003FFFC};
        tbl[8] = '{16'h1234, EXT_UPPER,     32'h12340000};
        tbl[9] = '{16'h0000, EXT_SIGN,      32'h00000000};

        tbl8[0] = '{8'hF0, EXT_SIGN_SHL2, 16'hFFC0};
        tbl8[1] = '{8'hF0, EXT_UPPER,     16'hF000};
        tbl8[2] = '{8'hF0, EXT_SIGN,      16'hFFF0};
        tbl8[3] = '{8'h7F, EXT_SIGN_SHL2, 16'h01FC};

        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_op     = EXT_ZERO;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        b8.in_valid   = 1'b0;
        b8.in_imm     = '0;
        b8.in_op      = EXT_ZERO;
        b8.in_tag     = '0;
        b8.out_ready  = 1'b1;

        // reset state
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sticky", bus.err_sticky, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("rel_ready", bus.in_ready, 1);
        chk("rel_valid", bus.out_valid, 0);

        // back-to-back modes, one cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = tbl[i].imm;
            bus.in_op    = tbl[i].op;
            bus.in_tag   = 5'(i);
            tick();
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_data", bus.out_data, tbl[i].exp);
            chk("t1_tag", bus.out_tag, i);
            chk("t1_err", bus.out_err, 0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t1_drain", bus.out_valid, 0);

        // stall: skid fills, then drains in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h8001;
        bus.in_op     = EXT_SIGN;
        bus.in_tag    = 5'd1;
        tick();
        chk("t2_rdy1", bus.in_ready, 1);
        chk("t2_d1", bus.out_data, 32'hFFFF8001);
        bus.in_imm = 16'h0042;
        bus.in_op  = EXT_UPPER;
        bus.in_tag = 5'd2;
        tick();
        chk("t2_rdy2", bus.in_ready, 0);
        chk("t2_d2", bus.out_data, 32'hFFFF8001);
        for (int i = 0; i < 2; i++) begin
            bus.in_imm = 16'h7777;
            bus.in_op  = EXT_ZERO;
            bus.in_tag = 5'(3 + i);
            tick();
            chk("t2_rdy_hold", bus.in_ready, 0);
            chk("t2_d_hold", bus.out_data, 32'hFFFF8001);
            chk("t2_tag_hold", bus.out_tag, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t2_pop_data", bus.out_data, 32'h00420000);
        chk("t2_pop_tag", bus.out_tag, 2);
        chk("t2_pop_rdy", bus.in_ready, 1);
        tick();
        chk("t2_empty", bus.out_valid, 0);

        // illegal ops and the sticky flag
        chk("t4_clear", bus.err_sticky, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = EXT_SIGN;
        bus.in_imm    = 16'h0001;
        tick();
        tick();
        chk("t4_full", bus.in_ready, 0);
        bus.in_op = 3'd7;
        tick();
        tick();
        chk("t4_no_set", bus.err_sticky, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("t4_drain", bus.out_valid, 0);
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd6;
        bus.in_imm    = 16'h1234;
        bus.in_tag    = 5'd9;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_valid", bus.out_valid, 1);
        chk("t4_data", bus.out_data, 0);
        chk("t4_err", bus.out_err, 1);
        chk("t4_tag", bus.out_tag, 9);
        chk("t4_sticky", bus.err_sticky, 1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("t4_stays", bus.err_sticky, 1);
        chk("t4_gone", bus.out_valid, 0);

        // reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = EXT_SIGN;
        bus.in_imm    = 16'hABCD;
        bus.in_tag    = 5'd7;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("t5_full", bus.in_ready, 0);
        #4;
        reset = 1'b0;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_sticky", bus.err_sticky, 0);
        chk("t5_ready", bus.in_ready, 0);
        chk("t5_data", bus.out_data, 0);
        chk("t5_tag", bus.out_tag, 0);
        chk("t5_err", bus.out_err, 0);
        tick();
        chk("t5_hold", bus.out_valid, 0);
        #2;
        reset = 1'b1;
        tick();
        chk("t5_rel_rdy", bus.in_ready, 1);
        chk("t5_rel_vld", bus.out_valid, 0);
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0001;
        bus.in_op     = EXT_SIGN;
        bus.in_tag    = 5'd3;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_new_vld", bus.out_valid, 1);
        chk("t5_new_data", bus.out_data, 32'h00000001);
        chk("t5_new_tag", bus.out_tag, 3);
        tick();
        chk("t5_new_pop", bus.out_valid, 0);

        // randomized stream against the queue model
        outs  = 0;
        cyc   = 0;
        tag_n = 0;
        while (outs < 1000 && cyc < 20000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_imm    = 16'($urandom);
            bus.in_op     = ($urandom_range(0, 9) == 0)
                            ? 3'($urandom_range(5, 7))
                            : 3'($urandom_range(0, 4));
            bus.in_tag    = 5'(tag_n);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            chk("r_ready", bus.in_ready, q.size() < 2);
            chk("r_valid", bus.out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("r_data", bus.out_data, q[0].data);
                chk("r_tag", bus.out_tag, q[0].tag);
                chk("r_err", bus.out_err, q[0].err);
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                outs++;
            end
            if (bus.in_valid && bus.in_ready) begin
                e.data = ref_ext(bus.in_imm, bus.in_op, 16, 32, er);
                e.err  = er;
                e.tag  = tag_n % 32;
                q.push_back(e);
                tag_n++;
            end
            tick();
            cyc++;
        end
        if (outs < 1000) chk("r_budget", outs, 1000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // narrow instance
        for (int i = 0; i < 4; i++) begin
            b8.in_valid = 1'b1;
            b8.in_imm   = tbl8[i].imm;
            b8.in_op    = tbl8[i].op;
            b8.in_tag   = 5'(i);
            tick();
            chk("t6_valid", b8.out_valid, 1);
            chk("t6_data", b8.out_data, tbl8[i].exp);
        end
        b8.in_valid = 1'b0;
        tick();
        chk("t6_drain", b8.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
